// File: rtl/dram_port_arbiter_if.sv
// Requester-side bus for one DRAM arbiter port: request, write data and read return.
interface dram_port_arbiter_if #(
    parameter int unsigned AddrW = 16,
    parameter int unsigned DataW = 32
);
    logic             req;
    logic [AddrW-1:0] addr;
    logic [3:0]       we;
    logic [DataW-1:0] wdata;
    logic             gnt;
    logic             rvalid;
    logic [DataW-1:0] rdata;

    modport master (
        output req,
        output addr,
        output we,
        output wdata,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        input  we,
        input  wdata,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/dram_port_arbiter.sv
// Two-port arbiter for a single-port data DRAM: port 0 has priority, port 1 is
// starvation-protected; reads are returned one cycle after their grant.
module dram_port_arbiter #(
    parameter int unsigned AddrW     = 16,
    parameter int unsigned DataW     = 32,
    parameter int unsigned StarveMax = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    dram_port_arbiter_if.slave   p0_io,
    dram_port_arbiter_if.slave   p1_io,
    output logic [AddrW-1:0]     dram_a_o,
    output logic [3:0]           dram_we_o,
    output logic [DataW-1:0]     dram_din_o,
    input  logic [DataW-1:0]     dram_spo_i
);
    localparam int unsigned    CntW   = (StarveMax > 0) ? $clog2(StarveMax + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(StarveMax);

    logic [CntW-1:0]  starve_cnt_q, starve_cnt_d;
    logic [AddrW-1:0] last_a_q, last_a_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_owner_q, rd_owner_d;

    logic             force1;
    logic             p0_gnt, p1_gnt;
    logic             any_gnt;
    logic             gnt_is_read;

    // Arbitration: port 1 jumps ahead once it has waited StarveMax cycles.
    always_comb begin
        force1      = (starve_cnt_q == CntMax);
        p0_gnt      = p0_io.req & ~(force1 & p1_io.req) & ~rst_i;
        p1_gnt      = p1_io.req & (~p0_io.req | force1) & ~rst_i;
        any_gnt     = p0_gnt | p1_gnt;
        gnt_is_read = (p0_gnt & (p0_io.we == 4'b0000)) | (p1_gnt & (p1_io.we == 4'b0000));
    end

    assign p0_io.gnt = p0_gnt;
    assign p1_io.gnt = p1_gnt;

    // Idle cycles hold the last address so spo stays stable.
    always_comb begin
        dram_a_o   = last_a_q;
        dram_we_o  = 4'b0000;
        dram_din_o = '0;
        if (p0_gnt) begin
            dram_a_o   = p0_io.addr;
            dram_we_o  = p0_io.we;
            dram_din_o = p0_io.wdata;
        end else if (p1_gnt) begin
            dram_a_o   = p1_io.addr;
            dram_we_o  = p1_io.we;
            dram_din_o = p1_io.wdata;
        end
    end

    always_comb begin
        starve_cnt_d = '0;
        if (p1_io.req && !p1_gnt) begin
            starve_cnt_d = (starve_cnt_q == CntMax) ? CntMax : starve_cnt_q + 1'b1;
        end

        last_a_d = last_a_q;
        if (any_gnt) begin
            last_a_d = dram_a_o;
        end

        rd_pend_d  = any_gnt & gnt_is_read;
        rd_owner_d = p1_gnt;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
            last_a_q     <= '0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            last_a_q     <= last_a_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // A read pending across a reset edge is dropped by gating with rst_i.
    always_comb begin
        p0_io.rvalid = rd_pend_q & ~rd_owner_q & ~rst_i;
        p1_io.rvalid = rd_pend_q & rd_owner_q & ~rst_i;
        p0_io.rdata  = p0_io.rvalid ? dram_spo_i : '0;
        p1_io.rdata  = p1_io.rvalid ? dram_spo_i : '0;
    end
endmodule

// File: tb/tb_dram_port_arbiter.sv
// Bench for dram_port_arbiter: directed vector table plus randomized traffic against
// a behavioural model with a shadow memory.
module tb_dram_port_arbiter;
    localparam int unsigned StarveMax = 4;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] CF = 32'hCAFEF00D;
    localparam logic [31:0] A5 = 32'hA5A5A5A5;
    localparam logic [31:0] C1 = 32'h12345678;
    localparam logic [31:0] BC = 32'h0BADCAFE;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] dram_a;
    logic [3:0]  dram_we;
    logic [31:0] dram_din;
    logic [31:0] dram_spo;

    logic        mem_clr, mem_ld;
    logic [7:0]  ld_a;
    logic [31:0] ld_d;
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;

    dram_port_arbiter_if #(.AddrW(16), .DataW(32)) p0_bus ();
    dram_port_arbiter_if #(.AddrW(16), .DataW(32)) p1_bus ();

    dram_port_arbiter #(
        .AddrW    (16),
        .DataW    (32),
        .StarveMax(StarveMax)
    ) u_dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .p0_io     (p0_bus),
        .p1_io     (p1_bus),
        .dram_a_o  (dram_a),
        .dram_we_o (dram_we),
        .dram_din_o(dram_din),
        .dram_spo_i(dram_spo)
    );

    always #5 clk = ~clk;

    // DRAM model: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_ld) begin
            mem[ld_a] <= ld_d;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (dram_we[b]) mem[dram_a[7:0]][8*b +: 8] <= dram_din[8*b +: 8];
            end
        end
        dram_spo <= mem[dram_a[7:0]];
    end

    typedef struct {
        logic        rst;
        logic        r0;
        logic [15:0] a0;
        logic [3:0]  w0;
        logic [31:0] d0;
        logic        r1;
        logic [15:0] a1;
        logic [3:0]  w1;
        logic [31:0] d1;
        logic        g0, g1;
        logic        rv0;
        logic [31:0] rd0;
        logic        rv1;
        logic [31:0] rd1;
        logic [3:0]  dwe;
        logic [15:0] da;
        logic [31:0] din;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rs, input logic r0, input logic [15:0] a0,
                       input logic [3:0] w0, input logic [31:0] d0, input logic r1,
                       input logic [15:0] a1, input logic [3:0] w1, input logic [31:0] d1,
                       input logic g0, input logic g1, input logic rv0, input logic [31:0] rd0,
                       input logic rv1, input logic [31:0] rd1, input logic [3:0] dwe,
                       input logic [15:0] da, input logic [31:0] din);
        vec_t v;
        v.rst = rs;  v.r0 = r0;   v.a0 = a0;   v.w0 = w0;   v.d0 = d0;
        v.r1 = r1;   v.a1 = a1;   v.w1 = w1;   v.d1 = d1;
        v.g0 = g0;   v.g1 = g1;   v.rv0 = rv0; v.rd0 = rd0; v.rv1 = rv1; v.rd1 = rd1;
        v.dwe = dwe; v.da = da;   v.din = din;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rs, input logic r0, input logic [15:0] a0,
                         input logic [3:0] w0, input logic [31:0] d0, input logic r1,
                         input logic [15:0] a1, input logic [3:0] w1, input logic [31:0] d1);
        rst          = rs;
        p0_bus.req   = r0; p0_bus.addr = a0; p0_bus.we = w0; p0_bus.wdata = d0;
        p1_bus.req   = r1; p1_bus.addr = a1; p1_bus.we = w1; p1_bus.wdata = d1;
    endtask

    task automatic check_all(input string tag, input logic g0, input logic g1,
                             input logic rv0, input logic [31:0] rd0, input logic rv1,
                             input logic [31:0] rd1, input logic [3:0] dwe,
                             input logic [15:0] da, input logic [31:0] din);
        chk({tag, " p0_gnt"},    32'(p0_bus.gnt),    32'(g0));
        chk({tag, " p1_gnt"},    32'(p1_bus.gnt),    32'(g1));
        chk({tag, " p0_rvalid"}, 32'(p0_bus.rvalid), 32'(rv0));
        chk({tag, " p0_rdata"},  p0_bus.rdata,       rd0);
        chk({tag, " p1_rvalid"}, 32'(p1_bus.rvalid), 32'(rv1));
        chk({tag, " p1_rdata"},  p1_bus.rdata,       rd1);
        chk({tag, " dram_we"},   32'(dram_we),       32'(dwe));
        chk({tag, " dram_a"},    32'(dram_a),        32'(da));
        chk({tag, " dram_din"},  dram_din,           din);
    endtask

    // Random-phase model state.
    int          p1_denied;
    logic [15:0] m_last_a;
    logic        m_rsp_v, m_rsp_p1;
    logic [31:0] m_rsp_d;
    logic        pend0, pend1;
    logic [15:0] ra0, ra1;
    logic [3:0]  rw0, rw1;
    logic [31:0] rd0_w, rd1_w;

    initial begin
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        mem_clr = 1'b1; mem_ld = 1'b0; ld_a = '0; ld_d = '0;
        @(negedge clk);
        mem_clr = 1'b0; mem_ld = 1'b1; ld_a = 8'h10; ld_d = DB;
        @(negedge clk);
        ld_a = 8'h08; ld_d = CF;
        @(negedge clk);
        mem_ld = 1'b0;

        //  rst r0 a0    w0   d0    r1 a1    w1   d1      g0 g1 rv0 rd0 rv1 rd1   dwe  da     din
        add(1, 1,'h10, 0,   0,    0, 0,    0,   0,      0, 0, 0, 0,  0, 0,    0,   'h00, 0);
        add(0, 1,'h10, 0,   0,    0, 0,    0,   0,      1, 0, 0, 0,  0, 0,    0,   'h10, 0);
        add(0, 0, 0,   0,   0,    0, 0,    0,   0,      0, 0, 1, DB, 0, 0,    0,   'h10, 0);
        add(0, 1,'h04,'hF,  A5,   1,'h08,  0,   0,      1, 0, 0, 0,  0, 0,   'hF,  'h04, A5);
        add(0, 0, 0,   0,   0,    1,'h08,  0,   0,      0, 1, 0, 0,  0, 0,    0,   'h08, 0);
        add(0, 0, 0,   0,   0,    0, 0,    0,   0,      0, 0, 0, 0,  1, CF,   0,   'h08, 0);
        add(0, 1,'h10, 0,   0,    1,'h04,  0,   0,      1, 0, 0, 0,  0, 0,    0,   'h10, 0);
        add(0, 1,'h10, 0,   0,    1,'h04,  0,   0,      1, 0, 1, DB, 0, 0,    0,   'h10, 0);
        add(0, 1,'h10, 0,   0,    1,'h04,  0,   0,      1, 0, 1, DB, 0, 0,    0,   'h10, 0);
        add(0, 1,'h10, 0,   0,    1,'h04,  0,   0,      1, 0, 1, DB, 0, 0,    0,   'h10, 0);
        add(0, 1,'h10, 0,   0,    1,'h04,  0,   0,      0, 1, 1, DB, 0, 0,    0,   'h04, 0);
        add(0, 1,'h10, 0,   0,    1,'h20, 'hF,  C1,     1, 0, 0, 0,  1, A5,   0,   'h10, 0);
        add(0, 1,'h10, 0,   0,    1,'h20, 'hF,  C1,     1, 0, 1, DB, 0, 0,    0,   'h10, 0);
        add(0, 1,'h10, 0,   0,    1,'h20, 'hF,  C1,     1, 0, 1, DB, 0, 0,    0,   'h10, 0);
        add(0, 1,'h10, 0,   0,    1,'h20, 'hF,  C1,     1, 0, 1, DB, 0, 0,    0,   'h10, 0);
        add(0, 1,'h10, 0,   0,    1,'h20, 'hF,  C1,     0, 1, 1, DB, 0, 0,   'hF,  'h20, C1);
        add(0, 0, 0,   0,   0,    1,'h20, 'h1, 'hFF,    0, 1, 0, 0,  0, 0,   'h1,  'h20, 'hFF);
        add(0, 0, 0,   0,   0,    1,'h20,  0,   0,      0, 1, 0, 0,  0, 0,    0,   'h20, 0);
        add(0, 0, 0,   0,   0,    0, 0,    0,   0,      0, 0, 0, 0,  1, 'h123456FF, 0, 'h20, 0);
        add(0, 1,'h30,'hF,  BC,   0, 0,    0,   0,      1, 0, 0, 0,  0, 0,   'hF,  'h30, BC);
        for (int i = 0; i < 5; i++) begin
            add(0, 0, 0,   0,   0,    0, 0,    0,   0,      0, 0, 0, 0,  0, 0,    0,   'h30, 0);
        end
        add(0, 1,'h30, 0,   0,    0, 0,    0,   0,      1, 0, 0, 0,  0, 0,    0,   'h30, 0);
        add(1, 1,'h10,'hF,  0,    0, 0,    0,   0,      0, 0, 0, 0,  0, 0,    0,   'h30, 0);
        add(0, 0, 0,   0,   0,    1,'h08,  0,   0,      0, 1, 0, 0,  0, 0,    0,   'h08, 0);
        add(0, 0, 0,   0,   0,    0, 0,    0,   0,      0, 0, 0, 0,  1, CF,   0,   'h08, 0);
        add(1, 0, 0,   0,   0,    0, 0,    0,   0,      0, 0, 0, 0,  0, 0,    0,   'h08, 0);
        add(0, 0, 0,   0,   0,    0, 0,    0,   0,      0, 0, 0, 0,  0, 0,    0,   'h00, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].r0, tbl[i].a0, tbl[i].w0, tbl[i].d0,
                  tbl[i].r1, tbl[i].a1, tbl[i].w1, tbl[i].d1);
            #1;
            check_all($sformatf("vec%0d", i), tbl[i].g0, tbl[i].g1, tbl[i].rv0, tbl[i].rd0,
                      tbl[i].rv1, tbl[i].rd1, tbl[i].dwe, tbl[i].da, tbl[i].din);
            @(negedge clk);
        end

        // Randomized phase: shadow memory starts as a copy of the DRAM contents.
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        p1_denied = 0; m_last_a = '0; m_rsp_v = 1'b0; m_rsp_p1 = 1'b0; m_rsp_d = '0;
        pend0 = 1'b0; pend1 = 1'b0;
        ra0 = '0; ra1 = '0; rw0 = '0; rw1 = '0; rd0_w = '0; rd1_w = '0;

        for (int cyc = 0; cyc < 2000; cyc++) begin
            logic        rs, e_g0, e_g1, e_rv0, e_rv1, gr_wr;
            logic [31:0] e_rd0, e_rd1, e_din;
            logic [3:0]  e_we, gr_we;
            logic [15:0] e_a, gr_a;
            logic [31:0] gr_d;

            rs = ($urandom_range(0, 63) == 0);
            if (!pend0 && $urandom_range(0, 99) < 85) begin
                pend0 = 1'b1; ra0 = 16'($urandom_range(0, 15)); rd0_w = $urandom;
                rw0 = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            if (!pend1 && $urandom_range(0, 99) < 50) begin
                pend1 = 1'b1; ra1 = 16'($urandom_range(0, 15)); rd1_w = $urandom;
                rw1 = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            drive(rs, pend0, pend0 ? ra0 : 16'($urandom), pend0 ? rw0 : 4'($urandom),
                  pend0 ? rd0_w : $urandom, pend1, pend1 ? ra1 : 16'($urandom),
                  pend1 ? rw1 : 4'($urandom), pend1 ? rd1_w : $urandom);

            // Port 1 wins when port 0 is idle or it has already been refused StarveMax times.
            e_g1 = !rs && pend1 && (!pend0 || p1_denied >= StarveMax);
            e_g0 = !rs && pend0 && !e_g1;
            gr_a  = e_g0 ? ra0 : ra1;
            gr_we = e_g0 ? rw0 : rw1;
            gr_d  = e_g0 ? rd0_w : rd1_w;
            e_a   = (e_g0 || e_g1) ? gr_a : m_last_a;
            e_we  = (e_g0 || e_g1) ? gr_we : 4'h0;
            e_din = (e_g0 || e_g1) ? gr_d : 32'h0;
            e_rv0 = !rs && m_rsp_v && !m_rsp_p1;
            e_rv1 = !rs && m_rsp_v && m_rsp_p1;
            e_rd0 = e_rv0 ? m_rsp_d : 32'h0;
            e_rd1 = e_rv1 ? m_rsp_d : 32'h0;

            #1;
            check_all($sformatf("rnd%0d", cyc), e_g0, e_g1, e_rv0, e_rd0, e_rv1, e_rd1,
                      e_we, e_a, e_din);

            if (rs) begin
                p1_denied = 0; m_last_a = '0; m_rsp_v = 1'b0;
            end else begin
                gr_wr   = (gr_we != 4'h0);
                m_rsp_v = (e_g0 || e_g1) && !gr_wr;
                m_rsp_p1 = e_g1;
                if (e_g0 || e_g1) begin
                    m_last_a = gr_a;
                    if (!gr_wr) m_rsp_d = ref_mem[gr_a[7:0]];
                    for (int b = 0; b < 4; b++) begin
                        if (gr_we[b]) ref_mem[gr_a[7:0]][8*b +: 8] = gr_d[8*b +: 8];
                    end
                end
                p1_denied = (pend1 && !e_g1) ? p1_denied + 1 : 0;
                if (e_g0) pend0 = 1'b0;
                if (e_g1) pend1 = 1'b0;
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
